reg_file_rename: RTL
====================

Name: reg_file_rename

Overview:
- Architectural register file with a per-register rename tag. Sits directly downstream of the reorder buffer's commit port and upstream of dispatch operand lookup.
- Holds 32 committed register values plus, for each register, the ROB tag of its youngest in-flight producer (0 = value is committed/valid).
- Dispatch reads operand values and tags, then renames its rd. ROB commit writes values back and releases tags. Clear drops all tags.

Parameters:
- XLEN, 32, register value width
- REG_NUM, 32, number of architectural registers; index 0 hardwired to zero
- TAG_W, 5, ROB tag width; tag 0 reserved for "no producer", legal tags 1..16

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global enable; low = hold all state
- clear  input  1  misprediction flush from ROB
- rs1_addr  input  5  dispatch source 1 index
- rs2_addr  input  5  dispatch source 2 index
- rs1_val  output  XLEN  committed value of rs1 (comb)
- rs2_val  output  XLEN  committed value of rs2 (comb)
- rs1_rely  output  TAG_W  producer tag of rs1, 0 if none (comb)
- rs2_rely  output  TAG_W  producer tag of rs2, 0 if none (comb)
- dispatch_rdy  input  1  rename request valid
- dispatch_rd  input  5  destination register being renamed
- dispatch_tag  input  TAG_W  ROB tag allocated to the dispatched instruction
- write_rdy  input  1  ROB commit write valid
- to_rd  input  5  commit destination
- write_val  input  XLEN  commit value
- head_tag  input  TAG_W  ROB tag of the committing entry
- busy_cnt  output  6  number of registers with nonzero tag (registered)

Behaviour:
- Reset: rst_in high at a clock edge sets all values to 0, all tags to 0, and busy_cnt to 0. The comb outputs then read 0. Reset overrides every other input.
- Reads are combinational from current state. Index 0 always returns val 0 and rely 0.
- When rdy_in is low, no state changes. Comb outputs still reflect current state.
- Commit (write_rdy=1, to_rd!=0): value[to_rd] <= write_val at the edge.
  - If tag[to_rd]==head_tag, tag[to_rd] <= 0.
  - Otherwise the tag is kept, because a younger producer owns it.
- Rename (dispatch_rdy=1, dispatch_rd!=0): tag[dispatch_rd] <= dispatch_tag.
- Same cycle, same register: rename wins the tag; the commit value is still written.
- Writes and renames to x0 are ignored.
- clear=1: all tags <= 0. A commit in the same cycle still writes its value, since ROB asserts clear together with the final commit. Rename is ignored when clear=1.
- Priority per register tag: rst_in > clear > rename > commit release.
- busy_cnt is recomputed each edge from next-state tags. It has 1-cycle latency and wraps never (max 31).
- No internal FSM beyond the per-register state. All updates take effect 1 cycle after the inputs.

Optional Feature:
- Macro REGFILE_COMMIT_BYPASS_EN.
- Defined: when write_rdy=1, to_rd==rsN_addr!=0, and tag[rsN]==head_tag, the read bypasses state in the same cycle.
  - rsN_val = write_val
  - rsN_rely = 0
  - A same-cycle rename to that register does not affect the read.
- Undefined: reads show pre-edge state. The consumer resolves the value through the ROB forward path.

Test Plan:
- Reset: assert rst_in 2 cycles, read x5 → rs1_val=0, rs1_rely=0, busy_cnt=0.
- Rename and commit: dispatch rd=3 tag=4; next cycle rs1_addr=3 → rely=4. Commit to_rd=3 head_tag=4 val=0xDEADBEEF; next cycle → val=0xDEADBEEF, rely=0.
- Stale commit: rename x7 with tag 2, then tag 9. Commit x7 head_tag=2 val=0x11 → val=0x11, rely stays 9.
- Collision: in the same cycle, commit x4 tag 5 val=0x22 and rename x4 tag 6 → val=0x22, rely=6.
- Clear: rename x1,x2,x3 (busy_cnt=3), then clear with simultaneous commit x1 val=0x33 → all rely=0, x1=0x33, busy_cnt=0. Repeat with rdy_in=0 → no change.
- x0: rename and commit x0 with val=0x55 → rs1_addr=0 reads val 0, rely 0. With REGFILE_COMMIT_BYPASS_EN, commit x8 tag 3 val=0x77 while reading rs2_addr=8 → rs2_val=0x77, rely=0 in the same cycle.

Source files
------------

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags (tag 0 = committed value is current).
// Optional REGFILE_COMMIT_BYPASS_EN forwards a releasing commit straight onto the read ports.
module reg_file_rename #(
   parameter int XLEN    = 32,
   parameter int REG_NUM = 32,
   parameter int TAG_W   = 5
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   output logic [XLEN-1:0]  rs1_val,
   output logic [XLEN-1:0]  rs2_val,
   output logic [TAG_W-1:0] rs1_rely,
   output logic [TAG_W-1:0] rs2_rely,
   input  logic             dispatch_rdy,
   input  logic [4:0]       dispatch_rd,
   input  logic [TAG_W-1:0] dispatch_tag,
   input  logic             write_rdy,
   input  logic [4:0]       to_rd,
   input  logic [XLEN-1:0]  write_val,
   input  logic [TAG_W-1:0] head_tag,
   output logic [5:0]       busy_cnt
);

   logic [XLEN-1:0]  val_q [REG_NUM];
   logic [XLEN-1:0]  val_d [REG_NUM];
   logic [TAG_W-1:0] tag_q [REG_NUM];
   logic [TAG_W-1:0] tag_d [REG_NUM];
   logic [5:0]       busy_cnt_q;
   logic [5:0]       busy_cnt_d;

   logic commit_en;
   logic rename_en;

   assign commit_en = rdy_in && write_rdy && (to_rd != 5'd0);
   assign rename_en = rdy_in && dispatch_rdy && (dispatch_rd != 5'd0) && !clear;

   // Later assignments override earlier ones: commit release < rename < clear.
   always_comb begin
      for (int i = 0; i < REG_NUM; i++) begin
         val_d[i] = val_q[i];
         tag_d[i] = tag_q[i];
      end
      if (commit_en) begin
         val_d[to_rd] = write_val;
         if (tag_q[to_rd] == head_tag) tag_d[to_rd] = '0;
      end
      if (rename_en) tag_d[dispatch_rd] = dispatch_tag;
      if (rdy_in && clear) begin
         for (int i = 0; i < REG_NUM; i++) tag_d[i] = '0;
      end
      val_d[0] = '0;
      tag_d[0] = '0;
   end

   always_comb begin
      busy_cnt_d = 6'd0;
      for (int i = 1; i < REG_NUM; i++) begin
         if (tag_d[i] != '0) busy_cnt_d = busy_cnt_d + 6'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
         busy_cnt_q <= 6'd0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            val_q[i] <= val_d[i];
            tag_q[i] <= tag_d[i];
         end
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

`ifdef REGFILE_COMMIT_BYPASS_EN
   logic byp1;
   logic byp2;
   // A same-cycle rename only touches tag_d, so the forwarded read stays clean.
   assign byp1 = write_rdy && (to_rd == rs1_addr) && (tag_q[rs1_addr] == head_tag);
   assign byp2 = write_rdy && (to_rd == rs2_addr) && (tag_q[rs2_addr] == head_tag);
`else
   logic byp1;
   logic byp2;
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_comb begin
      rs1_val  = '0;
      rs1_rely = '0;
      if (rs1_addr != 5'd0) begin
         rs1_val  = byp1 ? write_val : val_q[rs1_addr];
         rs1_rely = byp1 ? '0 : tag_q[rs1_addr];
      end
   end

   always_comb begin
      rs2_val  = '0;
      rs2_rely = '0;
      if (rs2_addr != 5'd0) begin
         rs2_val  = byp2 ? write_val : val_q[rs2_addr];
         rs2_rely = byp2 ? '0 : tag_q[rs2_addr];
      end
   end

endmodule
